// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Wait-state memory responder with an internal word RAM and
//            byte-strobed writes.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRequest,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [3:0]  ByteEnable,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        Busy
);
    localparam int          C_AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  C_WAIT  = 4'(WAIT_STATES);
    localparam logic [32:0] C_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_error;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_enter;
    logic            w_write;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic            w_range_err;
    logic            w_lane_ok;
    logic [1:0]      w_low;
    logic            w_align_err;
    logic            w_err;
    logic [31:0]     w_offset;
    logic [C_AW-1:0] w_index;

    // With zero wait states the request is captured and committed on the same
    // edge, so the commit path must look at the live inputs while in IDLE.
    assign w_enter = ((r_state == S_IDLE) && MemRequest && (C_WAIT == 4'd0)) ||
                     ((r_state == S_WAIT) && (r_count == 4'd1));
    assign w_write = (r_state == S_IDLE) ? MemWrite   : r_write;
    assign w_addr  = (r_state == S_IDLE) ? Address    : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? WriteData  : r_wdata;
    assign w_be    = (r_state == S_IDLE) ? ByteEnable : r_be;

    assign w_range_err = ({1'b0, w_addr} < {1'b0, BASE_ADDR}) || ({1'b0, w_addr} >= C_LIMIT);

    always_comb begin
        w_lane_ok = 1'b1;
        w_low     = 2'd0;
        case (w_be)
            4'b0001: w_low = 2'd0;
            4'b0010: w_low = 2'd1;
            4'b0100: w_low = 2'd2;
            4'b1000: w_low = 2'd3;
            4'b0011: w_low = 2'd0;
            4'b1100: w_low = 2'd2;
            4'b1111: w_low = 2'd0;
            default: w_lane_ok = 1'b0;
        endcase
    end

    assign w_align_err = w_write && (!w_lane_ok || (w_addr[1:0] != w_low));
    assign w_err       = w_range_err || w_align_err;
    assign w_offset    = w_addr - BASE_ADDR;
    assign w_index     = C_AW'(w_offset >> 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MemRequest) begin
                        r_write <= MemWrite;
                        r_addr  <= Address;
                        r_wdata <= WriteData;
                        r_be    <= ByteEnable;
                        r_count <= C_WAIT;
                        r_state <= (C_WAIT == 4'd0) ? S_RESPOND : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= S_RESPOND;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            if (w_enter) begin
                r_error <= w_err;
                if (w_err) begin
                    r_rdata <= 32'd0;
                end else if (!w_write) begin
                    r_rdata <= r_mem[w_index];
                end
            end
        end
    end

    // The array has no reset; reset is still gated here so an aborted request never commits.
    always_ff @(posedge clk) begin
        if (!reset && w_enter && w_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ReadData = r_rdata;
    assign MemReady = (r_state == S_RESPOND);
    assign MemError = r_error && (r_state == S_RESPOND);
    assign Busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed bench for mem_responder with three wait-state settings.
// Revision : 1.0
// ============================================================================
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [31:0] addr [3];
    logic [31:0] wd [3];
    logic [3:0]  be [3];
    logic [31:0] rd [3];
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [2:0]  busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // u0: one wait state, u1: three wait states, u2: zero wait states at a non-zero base.
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) u0 (
        .clk(clk), .reset(reset), .MemRequest(req[0]), .MemWrite(we[0]), .Address(addr[0]),
        .WriteData(wd[0]), .ByteEnable(be[0]), .ReadData(rd[0]), .MemReady(rdy[0]),
        .MemError(err[0]), .Busy(busy[0]));
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0000_0000)) u1 (
        .clk(clk), .reset(reset), .MemRequest(req[1]), .MemWrite(we[1]), .Address(addr[1]),
        .WriteData(wd[1]), .ByteEnable(be[1]), .ReadData(rd[1]), .MemReady(rdy[1]),
        .MemError(err[1]), .Busy(busy[1]));
    mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0100)) u2 (
        .clk(clk), .reset(reset), .MemRequest(req[2]), .MemWrite(we[2]), .Address(addr[2]),
        .WriteData(wd[2]), .ByteEnable(be[2]), .ReadData(rd[2]), .MemReady(rdy[2]),
        .MemError(err[2]), .Busy(busy[2]));

    // One request on DUT d; returns data/error at the pulse, cycles after capture, and ready one cycle later.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                        input logic [3:0] b, output logic [31:0] rdata, output logic e,
                        output int lat, output logic pulse2);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data; be[d] = b;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0; we[d] = ~w; addr[d] = 32'hFFFF_FFFF; wd[d] = 32'h5A5A_5A5A; be[d] = 4'h0;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (rdy[d]) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        rdata = rd[d];
        e = err[d];
        @(negedge clk);
        pulse2 = rdy[d];
    endtask

    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    logic        r_p2;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if ({rdy[d], err[d], busy[d], rd[d]} !== 35'd0) begin
                miscompares++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b err=%b busy=%b rd=%h expected all 0",
                         d, rdy[d], err[d], busy[d], rd[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b expected 000", busy);
        end
    endtask

    task automatic test_preload();
        xact(0, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b0 || r_lat != 1) begin
            miscompares++;
            $display("FAIL preload_w5: got err=%b lat=%0d expected err=0 lat=1", r_err, r_lat);
        end
        xact(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, r_data, r_err, r_lat, r_p2);
        xact(0, 1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, r_data, r_err, r_lat, r_p2);
    endtask

    task automatic test_read_latency();
        xact(0, 1'b0, 32'h14, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_lat != 1) begin
            miscompares++;
            $display("FAIL read_latency: got %0d cycles expected 1", r_lat);
        end
        vectors++;
        if (r_data !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL read_data: got %h err=%b expected deadbeef err=0", r_data, r_err);
        end
        vectors++;
        if (r_p2 !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_one_cycle: got %b expected 0", r_p2);
        end
        vectors++;
        if (rd[0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL read_hold: got %h expected deadbeef", rd[0]);
        end
    endtask

    task automatic test_byte_write();
        xact(0, 1'b1, 32'h22, 32'h00AA_0000, 4'b0100, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b0 || r_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL byte_write_resp: got err=%b rd=%h expected err=0 rd=deadbeef", r_err, r_data);
        end
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_data !== 32'h11AA_3344) begin
            miscompares++;
            $display("FAIL byte_readback: got %h expected 11aa3344", r_data);
        end
        xact(0, 1'b1, 32'h22, 32'h5566_0000, 4'b1100, r_data, r_err, r_lat, r_p2);
        xact(0, 1'b0, 32'h23, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_data !== 32'h5566_3344 || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL half_readback: got %h err=%b expected 55663344 err=0", r_data, r_err);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] a_tab [3] = '{32'h21, 32'h21, 32'h20};
        logic [3:0]  b_tab [3] = '{4'b0011, 4'b0110, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            xact(0, 1'b1, a_tab[i], 32'hFFFF_FFFF, b_tab[i], r_data, r_err, r_lat, r_p2);
            vectors++;
            if (r_err !== 1'b1 || r_data !== 32'd0 || r_lat != 1) begin
                miscompares++;
                $display("FAIL misaligned_%0d: got err=%b rd=%h lat=%0d expected err=1 rd=0 lat=1",
                         i, r_err, r_data, r_lat);
            end
        end
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_data !== 32'h5566_3344) begin
            miscompares++;
            $display("FAIL misaligned_nowrite: got %h expected 55663344", r_data);
        end
    endtask

    task automatic test_range();
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b1 || r_data !== 32'd0) begin
            miscompares++;
            $display("FAIL range_high: got err=%b rd=%h expected err=1 rd=0", r_err, r_data);
        end
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b0 || r_data !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL range_base: got err=%b rd=%h expected err=0 rd=cafef00d", r_err, r_data);
        end
        // u2 window is 0x100..0x1FF
        xact(2, 1'b0, 32'hFC, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b1 || r_lat != 0) begin
            miscompares++;
            $display("FAIL range_low: got err=%b lat=%0d expected err=1 lat=0", r_err, r_lat);
        end
        xact(2, 1'b1, 32'h1FC, 32'h1357_9BDF, 4'hF, r_data, r_err, r_lat, r_p2);
        xact(2, 1'b0, 32'h1FC, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b0 || r_data !== 32'h1357_9BDF || r_lat != 0) begin
            miscompares++;
            $display("FAIL range_top_word: got err=%b rd=%h lat=%0d expected err=0 rd=13579bdf lat=0",
                     r_err, r_data, r_lat);
        end
        xact(2, 1'b0, 32'h200, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_err !== 1'b1) begin
            miscompares++;
            $display("FAIL range_end: got err=%b expected 1", r_err);
        end
    endtask

    task automatic test_reset_wait();
        int pulses = 0;
        xact(1, 1'b1, 32'h80, 32'h0BAD_F00D, 4'hF, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_lat != 3 || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ws3_latency: got lat=%0d err=%b expected lat=3 err=0", r_lat, r_err);
        end
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h80; wd[1] = 32'hFFFF_FFFF; be[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        vectors++;
        if (busy[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_busy: got %b expected 1", busy[1]);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rdy[1] || err[1]) pulses++;
        end
        vectors++;
        if ({rdy[1], err[1], busy[1], rd[1]} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_wait_outputs: got rdy=%b err=%b busy=%b rd=%h expected all 0",
                     rdy[1], err[1], busy[1], rd[1]);
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rdy[1] || err[1]) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_wait_pulses: got %0d expected 0", pulses);
        end
        xact(1, 1'b0, 32'h80, 32'h0, 4'h0, r_data, r_err, r_lat, r_p2);
        vectors++;
        if (r_data !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL reset_wait_nowrite: got %h expected 0badf00d", r_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen_rdy = '0;
        logic [7:0] seen_busy = '0;
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h1FC;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen_rdy[i]  = rdy[2];
            seen_busy[i] = busy[2];
        end
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (seen_rdy !== 8'b0101_0101) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b expected 01010101", seen_rdy);
        end
        vectors++;
        if (seen_busy !== 8'b0101_0101) begin
            miscompares++;
            $display("FAIL b2b_busy: got %b expected 01010101", seen_busy);
        end
        vectors++;
        if (rd[2] !== 32'h1357_9BDF) begin
            miscompares++;
            $display("FAIL b2b_data: got %h expected 13579bdf", rd[2]);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            addr[d] = 32'd0;
            wd[d]   = 32'd0;
            be[d]   = 4'd0;
        end
        test_reset();
        test_preload();
        test_read_latency();
        test_byte_write();
        test_misaligned();
        test_range();
        test_reset_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
